// File: rtl/frame_buffer_pkg.sv
// Shared sizes, FSM state type and helpers for the frame buffer write path.
package frame_buffer_pkg;

  localparam int unsigned FB_ADDR_W = 14;
  localparam int unsigned FB_DEPTH  = 16384;
  localparam int unsigned FB_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH,
    DONE
  } fb_state_e;

  // Number of pixels packed into one RAM word.
  function automatic int unsigned lanes_for(input int unsigned pixel_w);
    return FB_WORD_W / pixel_w;
  endfunction

endpackage

// File: rtl/frame_buffer_packer.sv
// Packs a pixel stream little-endian into 32-bit RAM words with linear addressing.
// Define FRAME_PACKER_WRAP_EN to wrap and overwrite when full instead of dropping words.
module frame_buffer_packer
  import frame_buffer_pkg::*;
#(
  parameter int unsigned ADDR  = FB_ADDR_W,
  parameter int unsigned PIXEL = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic                 pixel_valid,
  input  logic [PIXEL-1:0]     pixel_data,
  output logic                 pixel_ready,
  output logic [ADDR-1:0]      wr_addr,
  output logic [FB_WORD_W-1:0] wr_data,
  output logic                 wr_en,
  output logic [ADDR:0]        word_count,
  output logic                 overflow,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int unsigned LANES  = lanes_for(PIXEL);
  localparam int unsigned LANE_W = $clog2(LANES);

  fb_state_e            state_q, state_d;
  logic [LANE_W-1:0]    lane_q;
  logic [ADDR-1:0]      addr_q;
  logic [FB_WORD_W-1:0] pack_q;

  logic                 accept;
  logic                 end_hit;
  logic                 word_done;
  logic                 emit;
  logic                 full;
  logic [FB_WORD_W-1:0] merged;

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pixel_ready <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixel_ready <= (state_d == ACTIVE);
      busy        <= (state_d == ACTIVE) || (state_d == FLUSH);
      frame_done  <= (state_d == DONE);
    end
  end

  // Next state; frame_start restarts from any state and wins over frame_end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      ACTIVE:  if (frame_end) state_d = FLUSH;
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (frame_start) state_d = ACTIVE;
  end

  // Pixel acceptance and word emission decode.
  always_comb begin
    accept    = 1'b0;
    end_hit   = 1'b0;
    word_done = 1'b0;
    emit      = 1'b0;
    full      = word_count[ADDR];
    merged    = pack_q;
    if (state_q == ACTIVE && !frame_start) begin
      accept  = pixel_valid;
      end_hit = frame_end;
    end
    if (accept) begin
      merged = pack_q | (FB_WORD_W'(pixel_data) << (32'(lane_q) * PIXEL));
    end
    word_done = accept && (lane_q == LANE_W'(LANES - 1));
    // A partial word is padded out when the frame ends with lanes still occupied.
    emit = word_done || (end_hit && (accept || (lane_q != '0)));
  end

  // Packing register, address counter and RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q     <= '0;
      pack_q     <= '0;
      addr_q     <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (frame_start) begin
        lane_q     <= '0;
        pack_q     <= '0;
        addr_q     <= '0;
        wr_addr    <= '0;
        word_count <= '0;
        overflow   <= 1'b0;
      end else begin
        if (accept) begin
          lane_q <= lane_q + LANE_W'(1);
          pack_q <= merged;
        end
        if (emit) begin
          lane_q <= '0;
          pack_q <= '0;
          if (full) overflow <= 1'b1;
`ifdef FRAME_PACKER_WRAP_EN
          wr_en   <= 1'b1;
          wr_data <= merged;
          wr_addr <= addr_q;
          addr_q  <= addr_q + ADDR'(1);
          if (!full) word_count <= word_count + (ADDR+1)'(1);
`else
          if (!full) begin
            wr_en      <= 1'b1;
            wr_data    <= merged;
            wr_addr    <= addr_q;
            addr_q     <= addr_q + ADDR'(1);
            word_count <= word_count + (ADDR+1)'(1);
          end
`endif
        end
      end
    end
  end

endmodule

// File: doc/frame_buffer_packer.md
# frame_buffer_packer

Write-side front end of the 16K × 32-bit frame buffer RAM. It accepts a stream of narrow pixels between frame_start and frame_end pulses and packs them little-endian into 32-bit words. It drives the RAM's write port (wr_addr / wr_data / wr_en) with a linear address starting at 0, pads the final partial word, and reports word count, overflow and frame completion.

## Interface
- ADDR, 14: RAM word-address width; depth = 2**ADDR words.
- PIXEL, 8: pixel width in bits; legal values are 8 or 16. LANES = 32/PIXEL.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- frame_start  in  1  single-cycle pulse that begins a new frame.
- frame_end  in  1  single-cycle pulse; may coincide with the last pixel_valid.
- pixel_valid  in  1  pixel_data is valid this cycle.
- pixel_data  in  PIXEL  pixel value.
- pixel_ready  out  1  pixel is accepted when pixel_valid & pixel_ready.
- wr_addr  out  ADDR  RAM write address.
- wr_data  out  32  RAM write data.
- wr_en  out  1  RAM write strobe, one word per cycle.
- word_count  out  ADDR+1  words written this frame; saturates at 2**ADDR.
- overflow  out  1  sticky; cleared by frame_start or rst.
- frame_done  out  1  one-cycle pulse after the last word of a frame is written.
- busy  out  1  high in ACTIVE and FLUSH. The RAM read side must not read while busy.

## Operation
- States and transitions:
  - IDLE → ACTIVE on frame_start.
  - ACTIVE → FLUSH on frame_end.
  - FLUSH → DONE unconditionally.
  - DONE → IDLE unconditionally.
- pixel_ready = 1 only in ACTIVE. Pixels offered in any other state are ignored.
- Lane counter (log2(LANES) bits) selects the lane for each accepted pixel. The first pixel of a word goes to bits [PIXEL-1:0].
- When the pixel filling the last lane is accepted:
  - the word is registered to wr_data, wr_en = 1 next cycle at the current address;
  - the address then increments and the lane counter returns to 0.
- frame_end in ACTIVE: a simultaneously valid pixel is accepted first, then the state moves to FLUSH.
- In FLUSH, if the lane counter ≠ 0, the partial word is written with unused upper lanes zero.
  - A word completed by the last pixel is written in the FLUSH cycle itself, and no partial word follows.
- In DONE, frame_done = 1 for one cycle. word_count holds its final value until the next frame_start.
- frame_start in any state:
  - restarts the frame: address 0, lane counter 0, word_count 0, overflow 0, state → ACTIVE;
  - a pixel_valid in the same cycle is ignored;
  - frame_start has priority over a simultaneous frame_end.
- Full condition (word_count = 2**ADDR) when another word completes: overflow ← 1 and behaviour follows Configuration.
- Address arithmetic is modulo 2**ADDR. word_count is ADDR+1 bits and never wraps.

## Timing
- Reset values:
  - state IDLE;
  - wr_en 0, wr_addr 0, wr_data 0;
  - word_count 0, overflow 0, frame_done 0, busy 0, pixel_ready 0;
  - lane counter 0.
- rst mid-frame: all of the above apply the next cycle. A pending word is discarded and no further wr_en is issued.
- Latency: last-lane pixel accepted in cycle N → wr_en high in cycle N+1. Throughput is one pixel per cycle sustained.
- frame_end in cycle N → FLUSH in N+1 (padded write, if any, also in N+1) → frame_done in N+2 → IDLE in N+3.
- All outputs are registered. wr_en is never high for more than one cycle per word.

## Configuration
- FRAME_PACKER_WRAP_EN defined: when full, wr_addr wraps to 0 and writing continues, overwriting the oldest words. overflow = 1 and word_count stays at 2**ADDR.
- FRAME_PACKER_WRAP_EN undefined: when full, completed words are dropped (wr_en stays 0) and wr_addr holds at 2**ADDR−1. overflow = 1. pixel_ready stays 1 so upstream never stalls.

## Structure
- frame_buffer_pkg holds:
  - state enum (IDLE, ACTIVE, FLUSH, DONE);
  - FB_ADDR_W = 14, FB_DEPTH = 16384, FB_WORD_W = 32;
  - lanes_for(pixel_w) function.
- No sub-module. Lane packing is a shift/mux register kept inline, and the block stays a single module.

## Test plan
- PIXEL = 8; frame_start, pixels 0x01..0x08 back-to-back, frame_end with 0x08 → writes addr0 = 0x04030201, addr1 = 0x08070605; word_count = 2; frame_done 2 cycles after frame_end.
- Five pixels 0x01..0x05, then frame_end alone → addr0 = 0x04030201, FLUSH writes addr1 = 0x00000005; word_count = 2.
- ADDR = 2, 20 pixels, macro undefined → 4 writes (addr 0..3); overflow = 1 at the 5th word; wr_en stays 0 for words 5; word_count = 4. Macro defined → 5th word written at addr 0.
- frame_start after 6 pixels → no flush write for the 2 pending pixels; next 4 pixels land at addr0; overflow cleared.
- rst asserted one cycle after the 3rd lane of a word → no wr_en; all outputs at reset values next cycle; IDLE ignores pixels until frame_start.
- frame_start and frame_end in the same cycle in ACTIVE → ACTIVE, word_count = 0, frame_done not pulsed.
